// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a single-port word memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_wdata;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  // Misaligned, illegal-size or out-of-range accesses are rejected up front.
  function automatic logic f_is_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = 1'b0;
    if (sz == 2'b11) e = 1'b1;
    if (sz == 2'b01 && a[0]) e = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
    if ({2'b00, a[31:2]} >= LP_WORDS) e = 1'b1;
    return e;
  endfunction

  // Pick the addressed little-endian lane and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the old word with new store data.
  function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      r[{off, 3'b000} +: 8] = d[7:0];
    end else if (sz == 2'b01) begin
      if (off[1]) r[31:16] = d[15:0];
      else        r[15:0]  = d[15:0];
    end
    return r;
  endfunction

  assign w_accept = (r_state == IDLE) && req_valid;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: error -> RESP, word store -> WR, everything else reads first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (f_is_err(req_size, req_addr))          w_next = RESP;
          else if (req_we && req_size == 2'b10)      w_next = WR;
          else                                       w_next = RD;
        end
      end
      RD:      w_next = MERGE;
      MERGE:   w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request fields captured at the accept edge; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Write-data and response registers; responses only change on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wdata  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept && req_we) r_mem_wdata <= req_wdata;
      if (r_state == MERGE && r_we)
        r_mem_wdata <= f_merge(mem_rdata, r_size, r_addr[1:0], r_wdata);
      if (w_next == RESP) begin
        r_resp_err   <= (r_state == IDLE);
        r_resp_rdata <= (r_state == MERGE && !r_we) ?
                        f_extract(mem_rdata, r_size, r_addr[1:0], r_uns) : 32'h0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = (r_state == RESP);
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_we     = (r_state == WR);
  assign mem_addr   = (r_state == RD || r_state == WR) ? {2'b00, r_addr[31:2]} : 32'h0;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  load_store_unit #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, registered read.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[6:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Write monitor.
  int          we_cnt = 0;
  logic [31:0] last_wa = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_wa = mem_addr;
    end
  end

  // Response monitor: pop scoreboard and compare.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_lat"}, cyc, e.due);
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input string n, input logic we, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input logic er,
                      input logic [31:0] rd, input int lat, input int ci, input logic [31:0] cv);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.err = er; v.rdata = rd; v.lat = lat; v.chk_idx = ci; v.chk_val = cv;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string nm);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!req_ready && g < 50);
    if (!req_ready) chk({nm, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_resp_timeout"}, sb.size(), 32'h0);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   a0, wc0;
    exp_t e;
    wait_ready(v.name);
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    a0 = cyc;
    wc0 = we_cnt;
    e.name = v.name; e.err = v.err; e.rdata = v.rdata; e.due = a0 + v.lat;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_drain(v.name);
    chk({v.name, "_writes"}, we_cnt - wc0, (v.we && !v.err) ? 32'h1 : 32'h0);
    if (v.we && !v.err) chk({v.name, "_waddr"}, last_wa, v.addr >> 2);
    if (v.chk_idx >= 0) chk({v.name, "_mem"}, mem[v.chk_idx], v.chk_val);
  endtask

  // Start an access, then assert reset a given number of edges after accept.
  task automatic abort_at(input string nm, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input int edges,
                          input int idx, input logic [31:0] keep);
    int wc0;
    wait_ready(nm);
    drive(we, sz, 1'b0, a, wd);
    wc0 = we_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (edges) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_rst_mem_we"},    {31'h0, mem_we},     32'h0);
    chk({nm, "_rst_mem_addr"},  mem_addr,            32'h0);
    chk({nm, "_rst_mem_wdata"}, mem_wdata,           32'h0);
    chk({nm, "_rst_resp_vld"},  {31'h0, resp_valid}, 32'h0);
    chk({nm, "_rst_resp_err"},  {31'h0, resp_err},   32'h0);
    chk({nm, "_rst_rdata"},     resp_rdata,          32'h0);
    chk({nm, "_rst_ready"},     {31'h0, req_ready},  32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk({nm, "_ready_after"}, {31'h0, req_ready}, 32'h1);
    repeat (5) @(negedge clk);
    chk({nm, "_writes"}, we_cnt - wc0, 32'h0);
    chk({nm, "_mem_kept"}, mem[idx], keep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    //   name          we sz     u  addr      wdata         err rdata         lat idx val
    addv("st_w_10",    1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 0, 32'h0,        2,  4, 32'hDEADBEEF);
    addv("ld_w_10",    0, 2'b10, 0, 32'h010, 32'h0,        0, 32'hDEADBEEF, 3, -1, 32'h0);
    addv("st_w_init",  1, 2'b10, 0, 32'h010, 32'h11223344, 0, 32'h0,        2,  4, 32'h11223344);
    addv("st_b_12",    1, 2'b00, 0, 32'h012, 32'h123456AA, 0, 32'h0,        4,  4, 32'h11AA3344);
    addv("ld_b_s",     0, 2'b00, 0, 32'h012, 32'h0,        0, 32'hFFFFFFAA, 3, -1, 32'h0);
    addv("ld_b_u",     0, 2'b00, 1, 32'h012, 32'h0,        0, 32'h000000AA, 3, -1, 32'h0);
    addv("st_w_8001",  1, 2'b10, 0, 32'h010, 32'h80017FFF, 0, 32'h0,        2,  4, 32'h80017FFF);
    addv("ld_h_hi_s",  0, 2'b01, 0, 32'h012, 32'h0,        0, 32'hFFFF8001, 3, -1, 32'h0);
    addv("ld_h_lo_s",  0, 2'b01, 0, 32'h010, 32'h0,        0, 32'h00007FFF, 3, -1, 32'h0);
    addv("err_h_11",   0, 2'b01, 0, 32'h011, 32'h0,        1, 32'h0,        1, -1, 32'h0);
    addv("ld_h_hi_u",  0, 2'b01, 1, 32'h012, 32'h0,        0, 32'h00008001, 3, -1, 32'h0);
    addv("err_w_12",   0, 2'b10, 0, 32'h012, 32'h0,        1, 32'h0,        1, -1, 32'h0);
    addv("st_h_12",    1, 2'b01, 0, 32'h012, 32'hFFFF1234, 0, 32'h0,        4,  4, 32'h12347FFF);
    addv("ld_w_u",     0, 2'b10, 1, 32'h010, 32'h0,        0, 32'h12347FFF, 3, -1, 32'h0);
    addv("err_sz3",    0, 2'b11, 0, 32'h010, 32'h0,        1, 32'h0,        1, -1, 32'h0);
    addv("st_b_13",    1, 2'b00, 0, 32'h013, 32'h00000055, 0, 32'h0,        4,  4, 32'h55347FFF);
    addv("ld_b_11_s",  0, 2'b00, 0, 32'h011, 32'h0,        0, 32'h0000007F, 3, -1, 32'h0);
    addv("err_w_200",  0, 2'b10, 0, 32'h200, 32'h0,        1, 32'h0,        1, -1, 32'h0);
    addv("err_stb_200",1, 2'b00, 0, 32'h200, 32'h000000FF, 1, 32'h0,        1, -1, 32'h0);
    addv("err_st_sz3", 1, 2'b11, 0, 32'h010, 32'hFFFFFFFF, 1, 32'h0,        1,  4, 32'h55347FFF);
    addv("st_w_1fc",   1, 2'b10, 0, 32'h1FC, 32'hCAFEF00D, 0, 32'h0,        2, 127, 32'hCAFEF00D);
    addv("ld_b_1ff_s", 0, 2'b00, 0, 32'h1FF, 32'h0,        0, 32'hFFFFFFCA, 3, -1, 32'h0);
    addv("st_b_10",    1, 2'b00, 0, 32'h010, 32'hFFFFFF00, 0, 32'h0,        4,  4, 32'h55347F00);
    addv("ld_h_10_s",  0, 2'b01, 0, 32'h010, 32'h0,        0, 32'h00007F00, 3, -1, 32'h0);
    addv("err_h_13",   1, 2'b01, 0, 32'h013, 32'h0000BEEF, 1, 32'h0,        1,  4, 32'h55347F00);
    addv("st_w_14",    1, 2'b10, 0, 32'h014, 32'h01020304, 0, 32'h0,        2,  5, 32'h01020304);
    addv("st_w_18",    1, 2'b10, 0, 32'h018, 32'h5A5A5A5A, 0, 32'h0,        2,  6, 32'h5A5A5A5A);
    addv("ld_w_14",    0, 2'b10, 0, 32'h014, 32'h0,        0, 32'h01020304, 3, -1, 32'h0);

    // Reset state.
    #12;
    chk("reset_ready",      {31'h0, req_ready},  32'h0);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_resp_err",   {31'h0, resp_err},   32'h0);
    chk("reset_rdata",      resp_rdata,          32'h0);
    chk("reset_mem_we",     {31'h0, mem_we},     32'h0);
    chk("reset_mem_addr",   mem_addr,            32'h0);
    chk("reset_mem_wdata",  mem_wdata,           32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Aborted operations: reset in MERGE and RD of a partial store, and in WR.
    abort_at("abort_merge", 1'b1, 2'b00, 32'h014, 32'h000000EE, 1, 5, 32'h01020304);
    abort_at("abort_rd",    1'b1, 2'b01, 32'h016, 32'h0000EEEE, 0, 5, 32'h01020304);
    abort_at("abort_wr",    1'b1, 2'b10, 32'h018, 32'h99999999, 0, 6, 32'h5A5A5A5A);

    // Busy-cycle requests: req_valid held with new fields during a load.
    begin
      int   a0, g;
      exp_t e;
      wait_ready("busy");
      drive(1'b0, 2'b10, 1'b0, 32'h014, 32'h0);
      a0 = cyc;
      e.name = "busy_first";  e.err = 1'b0; e.rdata = 32'h01020304; e.due = a0 + 3;
      sb.push_back(e);
      @(posedge clk);
      #1 drive(1'b0, 2'b00, 1'b1, 32'h017, 32'h0);
      e.name = "busy_second"; e.err = 1'b0; e.rdata = 32'h00000001; e.due = a0 + 7;
      sb.push_back(e);
      g = 0;
      while (cyc != a0 + 4 && g < 20) begin
        @(negedge clk);
        g++;
      end
      chk("busy_ready_after_resp", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_drain("busy");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
